// File: rtl/div_iter_unit.sv
// div_iter_unit: multi-cycle radix-2 restoring DIV/DIVU with EX-stage stall request.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         div_type_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               annul_i,
    output logic               stallreq_for_ex,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam logic [1:0] DIV_TYPE_NONE = 2'b00;
    localparam logic [1:0] DIV_TYPE_DIV  = 2'b01;

    typedef enum logic [1:0] {IDLE, DIVZERO, RUN, DONE} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo, rem, dsr;
    logic             sgn, neg_a, neg_b;

    logic             req, in_sgn, in_neg_a, in_neg_b, early, fit, last;
    logic [WIDTH-1:0] mag_a, mag_b, quo_nxt, rem_nxt, fix_q, fix_r;
    logic [WIDTH:0]   partial;

    assign req      = div_type_i != DIV_TYPE_NONE;
    assign in_sgn   = div_type_i == DIV_TYPE_DIV;
    assign in_neg_a = in_sgn & dividend_i[WIDTH-1];
    assign in_neg_b = in_sgn & divisor_i[WIDTH-1];
    assign mag_a    = in_neg_a ? -dividend_i : dividend_i;
    assign mag_b    = in_neg_b ? -divisor_i : divisor_i;

`ifdef DIV_EARLY_OUT_EN
    assign early = mag_a < mag_b;
`else
    assign early = 1'b0;
`endif

    // One restoring step: the dividend register shifts its MSB into the
    // partial remainder and collects quotient bits at the bottom.
    assign partial = {rem, quo[WIDTH-1]} - {1'b0, dsr};
    assign fit     = ~partial[WIDTH];
    assign rem_nxt = fit ? partial[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign quo_nxt = {quo[WIDTH-2:0], fit};
    assign last    = cnt == CNT_W'(WIDTH - 1);
    assign fix_q   = (sgn && (neg_a ^ neg_b)) ? -quo_nxt : quo_nxt;
    assign fix_r   = (sgn && neg_a) ? -rem_nxt : rem_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; annul overrides everything
    always_comb begin
        next_state = state;
        if (annul_i) next_state = IDLE;
        else begin
            unique case (state)
                IDLE:    if (req) next_state = (divisor_i == '0) ? DIVZERO : early ? DONE : RUN;
                DIVZERO: next_state = DONE;
                RUN:     if (last) next_state = DONE;
                DONE:    if (!req) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs: stall until the result is held in DONE
    always_comb begin
        stallreq_for_ex = req && (state != DONE) && !annul_i;
        ready_o         = state == DONE;
    end

    // Datapath: latch operands, iterate, and publish the fixed-up result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dsr      <= '0;
            sgn      <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_o <= '0;
        end else if (annul_i) begin
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE: if (req && divisor_i != '0) begin
                    quo   <= mag_a;
                    dsr   <= mag_b;
                    rem   <= '0;
                    sgn   <= in_sgn;
                    neg_a <= in_neg_a;
                    neg_b <= in_neg_b;
                    cnt   <= '0;
                    if (early) result_o <= {dividend_i, {WIDTH{1'b0}}};
                end
                DIVZERO: result_o <= {dividend_i, {WIDTH{1'b1}}};
                RUN: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) result_o <= {fix_r, fix_q};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed scoreboard bench for div_iter_unit.
module tb_div_iter_unit;
    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] DIV  = 2'b01;
    localparam logic [1:0] DIVU = 2'b10;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  div_type;
    logic [31:0] dividend, divisor;
    logic        annul;
    logic        stallreq;
    logic        ready;
    logic [63:0] result;

    int total = 0;
    int bad = 0;
    logic [63:0] sb[$];
    logic [63:0] prev;

    div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .div_type_i(div_type),
        .dividend_i(dividend),
        .divisor_i(divisor),
        .annul_i(annul),
        .stallreq_for_ex(stallreq),
        .ready_o(ready),
        .result_o(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb2;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (t == DIVU) return {a % b, a / b};
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        return {32'(sa % sb2), 32'(sa / sb2)};
    endfunction

    function automatic int latency(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        if (b == 0) return 2;
        ma = (t == DIV) ? longint'($signed(a)) : longint'(a);
        mb = (t == DIV) ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        return (EARLY_EN && ma < mb) ? 1 : 33;
    endfunction

    task automatic do_div(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b, input int hold);
        int n = 0;
        int stalls = 0;
        int lat = latency(t, a, b);
        logic [63:0] exp;
        sb.push_back(model(t, a, b));
        @(negedge clk);
        div_type = t;
        dividend = a;
        divisor  = b;
        #1;
        while (!ready && n < 100) begin
            if (stallreq) stalls++;
            @(negedge clk);
            n++;
            if (n == 1 && b != 0) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            #1;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("stall_cycles", 64'(stalls), 64'(lat));
        chk("stall_in_done", 64'(stallreq), 64'd0);
        exp = sb.pop_front();
        chk("result", result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk("hold_ready", 64'(ready), 64'd1);
            chk("hold_result", result, exp);
        end
        @(negedge clk);
        div_type = NONE;
        #1;
        chk("drop_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        #1;
        chk("drop_ready", 64'(ready), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        div_type = NONE;
        dividend = '0;
        divisor = '0;
        annul = 1'b0;
        #3;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_stall", 64'(stallreq), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_div(DIVU, 32'd100, 32'd7, 0);
        do_div(DIV, 32'hFFFF_FFF9, 32'd2, 5);
        do_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div(DIVU, 32'd5, 32'd0, 0);
        do_div(DIV, 32'hFFFF_FF9C, 32'd0, 1);

        // Annul at RUN step 10
        @(negedge clk);
        div_type = DIVU;
        dividend = 32'd1000;
        divisor  = 32'd3;
        repeat (11) @(negedge clk);
        annul = 1'b1;
        #1;
        chk("annul_stall", 64'(stallreq), 64'd0);
        prev = result;
        @(negedge clk);
        annul = 1'b0;
        div_type = NONE;
        #1;
        chk("annul_ready", 64'(ready), 64'd0);
        chk("annul_result_kept", result, prev);
        do_div(DIVU, 32'd9, 32'd3, 0);

        do_div(DIVU, 32'd3, 32'd10, 0);
        do_div(DIV, 32'hFFFF_FF9C, 32'd7, 0);
        do_div(DIV, 32'd100, 32'hFFFF_FFF9, 0);
        do_div(DIVU, 32'hFFFF_FFFF, 32'd1, 0);
        do_div(DIVU, 32'hDEAD_BEEF, 32'h0001_2345, 0);

        // Async reset mid-RUN
        @(negedge clk);
        div_type = DIVU;
        dividend = 32'd77;
        divisor  = 32'd5;
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 64'd0);
        chk("midrst_ready", 64'(ready), 64'd0);
        @(negedge clk);
        div_type = NONE;
        rst_n = 1'b1;
        do_div(DIVU, 32'd77, 32'd5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
